// File: rtl/ftransform_sched_pkg.sv
// Shared state encoding and default width constants for the transform scheduler.
package ftransform_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LATCH, ST_START, ST_WAIT_FT, ST_WRITE, ST_NEXT, ST_DONE
  } state_t;

  localparam int DEF_BIT_WIDTH  = 8;
  localparam int DEF_BLOCK_SIZE = 4;
  localparam int DEF_NUM_BLK    = 16;

  // Widths for the default configuration; instances derive their own via pix_bits.
  localparam int PIX_BITS  = DEF_BIT_WIDTH * DEF_BLOCK_SIZE * DEF_BLOCK_SIZE;
  localparam int COEF_BITS = 2 * PIX_BITS;
  localparam int IDX_BITS  = $clog2(DEF_NUM_BLK);

  function automatic int pix_bits(input int bw, input int bs);
    return bw * bs * bs;
  endfunction

endpackage

// File: rtl/ftransform_sched_skip_scan.sv
// Next-index lookahead: successor index, whether it is masked, and end-of-macroblock flag.
module ftsched_skip_scan #(
  parameter int NUM_BLK  = 16,
  parameter int IDX_BITS = 4
) (
  input  logic [NUM_BLK-1:0]  skip,
  input  logic [IDX_BITS-1:0] idx,
  output logic                is_last,
  output logic [IDX_BITS-1:0] nxt_idx,
  output logic                nxt_skip
);

  assign is_last  = (idx == IDX_BITS'(NUM_BLK - 1));
  assign nxt_idx  = idx + IDX_BITS'(1);
  assign nxt_skip = skip[nxt_idx];

endmodule

// File: rtl/ftransform_sched.sv
// Macroblock scheduler: walks unskipped sub-blocks through fetch, transform and coefficient write.
module ftransform_sched
  import ftransform_sched_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_BLK    = DEF_NUM_BLK
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          mb_start,
  input  logic [NUM_BLK-1:0]                            mb_skip,
  input  logic                                          mb_abort,
  output logic                                          busy,
  output logic                                          mb_done,
  output logic [$clog2(NUM_BLK)-1:0]                    rd_addr,
  output logic                                          rd_en,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]    rd_src,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]    rd_ref,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]    ft_src,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]    ft_ref,
  output logic                                          ft_start,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE*2-1:0]  ft_out,
  input  logic                                          ft_done,
  output logic                                          wr_en,
  output logic [$clog2(NUM_BLK)-1:0]                    wr_addr,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE*2-1:0]  wr_data,
  input  logic                                          wr_ready,
  output logic [$clog2(NUM_BLK):0]                      blk_cnt
);

  localparam int PIXW = pix_bits(BIT_WIDTH, BLOCK_SIZE);
  localparam int IDXW = $clog2(NUM_BLK);

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx, idx_nxt;
  logic [NUM_BLK-1:0] skip_q;
  logic              ld_skip, clr_cnt, inc_cnt;
  logic              is_last, nxt_skip;
  logic [IDXW-1:0]   nxt_idx;

  ftsched_skip_scan #(.NUM_BLK(NUM_BLK), .IDX_BITS(IDXW)) u_scan (
    .skip    (skip_q),
    .idx     (idx),
    .is_last (is_last),
    .nxt_idx (nxt_idx),
    .nxt_skip(nxt_skip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ld_skip   = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    case (state)
      ST_IDLE: if (mb_start && !mb_abort) begin
        ld_skip   = 1'b1;
        clr_cnt   = 1'b1;
        idx_nxt   = '0;
        // Block 0 is judged here so an all-skip macroblock costs one cycle per index.
        state_nxt = mb_skip[0] ? ST_NEXT : ST_FETCH;
      end
      ST_FETCH:   state_nxt = ST_LATCH;
      ST_LATCH:   state_nxt = ST_START;
      ST_START:   state_nxt = ST_WAIT_FT;
      ST_WAIT_FT: if (ft_done) state_nxt = ST_WRITE;
      ST_WRITE: if (wr_ready) begin
        inc_cnt   = 1'b1;
        state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (is_last) state_nxt = ST_DONE;
        else begin
          idx_nxt   = nxt_idx;
          state_nxt = nxt_skip ? ST_NEXT : ST_FETCH;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (mb_abort && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      inc_cnt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q  <= '0;
      blk_cnt <= '0;
      ft_src  <= '0;
      ft_ref  <= '0;
      wr_data <= '0;
    end else begin
      if (ld_skip) skip_q <= mb_skip;
      if (clr_cnt)      blk_cnt <= '0;
      else if (inc_cnt) blk_cnt <= blk_cnt + (IDXW+1)'(1);
      // Operands only load in LATCH, so they hold steady for the whole engine run.
      if (state == ST_LATCH) begin
        ft_src <= rd_src[PIXW-1:0];
        ft_ref <= rd_ref[PIXW-1:0];
      end
      if (state == ST_WAIT_FT && ft_done && !mb_abort) wr_data <= ft_out;
    end
  end

  assign busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign mb_done  = (state == ST_DONE);
  assign rd_en    = (state == ST_FETCH);
  assign ft_start = (state == ST_START);
  assign wr_en    = (state == ST_WRITE);
  assign rd_addr  = idx;
  assign wr_addr  = idx;

endmodule

// File: tb/tb_ftransform_sched.sv
// Scoreboard bench for ftransform_sched with a pixel-buffer and fixed-latency engine model.
module tb_ftransform_sched;

  localparam int NB     = 16;
  localparam int PW     = 128;
  localparam int CW     = 256;
  localparam int FT_LAT = 3;

  typedef struct {
    int            addr;
    logic [CW-1:0] data;
  } wr_t;

  logic          clk, rst, mb_start, mb_abort, busy, mb_done, rd_en, ft_start, ft_done;
  logic          wr_en, wr_ready;
  logic [NB-1:0] mb_skip;
  logic [3:0]    rd_addr, wr_addr;
  logic [PW-1:0] rd_src, rd_ref, ft_src, ft_ref;
  logic [CW-1:0] ft_out, wr_data;
  logic [4:0]    blk_cnt;

  int  total, bad, cyc, n_rd, n_fts, n_wr, n_done, cd;
  wr_t sbq[$];

  ftransform_sched dut (
    .clk(clk), .rst(rst), .mb_start(mb_start), .mb_skip(mb_skip), .mb_abort(mb_abort),
    .busy(busy), .mb_done(mb_done), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_src(rd_src), .rd_ref(rd_ref), .ft_src(ft_src), .ft_ref(ft_ref),
    .ft_start(ft_start), .ft_out(ft_out), .ft_done(ft_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .blk_cnt(blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pix_src(input int a);
    logic [PW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(a * 16 + k);
    return r;
  endfunction

  function automatic logic [PW-1:0] pix_ref(input int a);
    logic [PW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(a * 5 + k * 3 + 100);
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_coef(input int a);
    logic [PW-1:0] s, r;
    s = pix_src(a);
    r = pix_ref(a);
    return {s ^ r, s + r};
  endfunction

  // Pixel buffer: data valid only the cycle after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_src <= pix_src(int'(rd_addr));
      rd_ref <= pix_ref(int'(rd_addr));
    end else begin
      rd_src <= {4{32'hDEADBEEF}};
      rd_ref <= {4{32'hBADC0FFE}};
    end
  end

  // Engine: ft_done FT_LAT cycles after ft_start, computed from the operands present then.
  always @(posedge clk) begin
    ft_done <= 1'b0;
    if (rst) cd <= 0;
    else if (ft_start) cd <= FT_LAT - 1;
    else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        ft_done <= 1'b1;
        ft_out  <= {ft_src ^ ft_ref, ft_src + ft_ref};
      end
    end
  end

  // Observes the current cycle mid-period, then advances to just after the next edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (rd_en) n_rd++;
    if (ft_start) n_fts++;
    if (mb_done) n_done++;
    if (wr_en && wr_ready) begin
      n_wr++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: unexpected write addr=%0d", wr_addr);
      end else begin
        e = sbq.pop_front();
        if (wr_addr !== 4'(e.addr) || wr_data !== e.data) begin
          bad++;
          $display("FAIL sb_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic [NB-1:0] skip, input int max_blk);
    wr_t e;
    for (int i = 0; i < max_blk; i++)
      if (!skip[i]) begin
        e.addr = i;
        e.data = exp_coef(i);
        sbq.push_back(e);
      end
  endtask

  // Runs one macroblock; lat = cycles from mb_start to mb_done, gap = first fetch-to-fetch.
  task automatic run_mb(input logic [NB-1:0] skip, output int lat, output int gap);
    int fa, fb;
    push_exp(skip, NB);
    mb_skip  = skip;
    mb_start = 1'b1;
    lat = 0; fa = -1; fb = -1;
    while (lat < 2000) begin
      tick();
      lat++;
      mb_skip  = ~skip;
      mb_start = (lat == 20) && busy;
      if (rd_en) begin
        if (fa < 0) fa = cyc;
        else if (fb < 0) fb = cyc;
      end
      if (mb_done) break;
    end
    mb_start = 1'b0;
    gap = (fb >= 0) ? fb - fa : -1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, mb_done, rd_en, ft_start, wr_en, rd_addr, wr_addr, blk_cnt, ft_src, ft_ref, wr_data} !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b rd=%b fts=%b wr=%b cnt=%0d ftsrc=%h wrdata=%h, want all zero",
               busy, mb_done, rd_en, ft_start, wr_en, blk_cnt, ft_src, wr_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full();
    int lat, gap, w0, d0, r0;
    w0 = n_wr; d0 = n_done; r0 = n_rd;
    run_mb(16'h0000, lat, gap);
    total++; if (lat !== 129) begin bad++; $display("FAIL full_latency: got %0d want 129", lat); end
    total++; if (gap !== FT_LAT + 5) begin bad++; $display("FAIL block_gap: got %0d want %0d", gap, FT_LAT + 5); end
    total++; if (blk_cnt !== 5'd16) begin bad++; $display("FAIL full_blk_cnt: got %0d want 16", blk_cnt); end
    total++;
    if (n_wr - w0 !== 16 || n_done - d0 !== 1 || n_rd - r0 !== 16 || sbq.size() !== 0) begin
      bad++;
      $display("FAIL full_counts: wr=%0d done=%0d rd=%0d left=%0d, want 16 1 16 0",
               n_wr - w0, n_done - d0, n_rd - r0, sbq.size());
    end
  endtask

  task automatic test_alt_skip();
    int lat, gap, w0;
    w0 = n_wr;
    run_mb(16'hAAAA, lat, gap);
    total++; if (lat !== 73) begin bad++; $display("FAIL alt_latency: got %0d want 73", lat); end
    total++; if (gap !== 9) begin bad++; $display("FAIL alt_gap: got %0d want 9", gap); end
    total++;
    if (blk_cnt !== 5'd8 || n_wr - w0 !== 8 || sbq.size() !== 0) begin
      bad++;
      $display("FAIL alt_counts: cnt=%0d wr=%0d left=%0d, want 8 8 0", blk_cnt, n_wr - w0, sbq.size());
    end
  endtask

  task automatic test_all_skip();
    int lat, gap, r0, f0, w0, d0;
    r0 = n_rd; f0 = n_fts; w0 = n_wr; d0 = n_done;
    run_mb(16'hFFFF, lat, gap);
    total++; if (lat !== NB + 1) begin bad++; $display("FAIL allskip_latency: got %0d want %0d", lat, NB + 1); end
    total++;
    if (n_rd - r0 !== 0 || n_fts - f0 !== 0 || n_wr - w0 !== 0 || n_done - d0 !== 1 || blk_cnt !== 5'd0) begin
      bad++;
      $display("FAIL allskip_strobes: rd=%0d fts=%0d wr=%0d done=%0d cnt=%0d, want 0 0 0 1 0",
               n_rd - r0, n_fts - f0, n_wr - w0, n_done - d0, blk_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic stalled, hold_ok;
    logic [CW-1:0] held;
    push_exp(16'h0000, NB);
    mb_skip = '0;
    mb_start = 1'b1;
    lat = 0; stalled = 1'b0; hold_ok = 1'b1;
    while (lat < 2000) begin
      tick();
      lat++;
      mb_start = 1'b0;
      if (wr_en && wr_addr == 4'd3 && !stalled) begin
        stalled  = 1'b1;
        wr_ready = 1'b0;
        held     = wr_data;
        for (int s = 0; s < 5; s++) begin
          if (!wr_en || wr_addr !== 4'd3 || wr_data !== held || ft_start) hold_ok = 1'b0;
          tick();
          lat++;
        end
        if (!wr_en || wr_addr !== 4'd3 || wr_data !== held) hold_ok = 1'b0;
        wr_ready = 1'b1;
      end
      if (mb_done) break;
    end
    tick();
    total++;
    if (!stalled || !hold_ok) begin
      bad++;
      $display("FAIL bp_hold: stalled=%b hold_ok=%b, want 1 1", stalled, hold_ok);
    end
    total++;
    if (lat !== 134 || blk_cnt !== 5'd16) begin
      bad++;
      $display("FAIL bp_latency: lat=%0d cnt=%0d, want 134 16", lat, blk_cnt);
    end
  endtask

  task automatic test_abort();
    int k, w0, d0, lat, gap;
    logic found;
    w0 = n_wr; d0 = n_done;
    push_exp(16'h0000, 7);
    mb_skip = '0;
    mb_start = 1'b1;
    found = 1'b0;
    for (k = 0; k < 500; k++) begin
      tick();
      mb_start = 1'b0;
      if (ft_start && rd_addr == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    tick();
    mb_abort = 1'b1;
    tick();
    mb_abort = 1'b0;
    total++;
    if (!found || busy !== 1'b0 || rd_en || ft_start || wr_en) begin
      bad++;
      $display("FAIL abort_idle: found=%b busy=%b rd=%b fts=%b wr=%b, want 1 0 0 0 0",
               found, busy, rd_en, ft_start, wr_en);
    end
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (n_wr - w0 !== 7 || n_done - d0 !== 0 || busy !== 1'b0 || sbq.size() !== 0) begin
      bad++;
      $display("FAIL abort_late_done: wr=%0d done=%0d busy=%b left=%0d, want 7 0 0 0",
               n_wr - w0, n_done - d0, busy, sbq.size());
    end
    mb_abort = 1'b1;
    mb_start = 1'b1;
    tick();
    mb_abort = 1'b0;
    mb_start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_same: busy=%b rd=%b, want 0 0", busy, rd_en);
    end
    run_mb(16'h0000, lat, gap);
    total++;
    if (lat !== 129 || blk_cnt !== 5'd16) begin
      bad++;
      $display("FAIL abort_restart: lat=%0d cnt=%0d, want 129 16", lat, blk_cnt);
    end
  endtask

  task automatic test_reset_in_write();
    logic found;
    push_exp(16'h0000, 1);
    wr_ready = 1'b0;
    mb_skip  = '0;
    mb_start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      mb_start = 1'b0;
      if (wr_en) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if (!found || {busy, mb_done, rd_en, ft_start, wr_en, rd_addr, wr_addr, blk_cnt, ft_src, ft_ref, wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_in_write: found=%b busy=%b wr=%b addr=%0d cnt=%0d wrdata=%h, want 1 and all zero",
               found, busy, wr_en, wr_addr, blk_cnt, wr_data);
    end
    rst = 1'b0;
    wr_ready = 1'b1;
    sbq.delete();
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_stays_idle: busy=%b wr=%b, want 0 0", busy, wr_en);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; n_rd = 0; n_fts = 0; n_wr = 0; n_done = 0;
    rst = 1'b1; mb_start = 1'b0; mb_abort = 1'b0; mb_skip = '0; wr_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_full();
    test_alt_skip();
    test_all_skip();
    test_backpressure();
    test_abort();
    test_reset_in_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
